// File: rtl/bas_multistart_ctrl_if.sv
// Result port of the bas multistart controller.
// The master side presents the global best point and value with res_valid.
// The slave side accepts the result with res_ready.
interface bas_multistart_ctrl_if #(
  parameter int RUN_W = 8
);
  logic                    res_valid;
  logic                    res_ready;
  logic [15:0]             best_x;
  logic [15:0]             best_y;
  logic signed [39:0]      best_value;
  logic [RUN_W-1:0]        best_run;

  modport master (
    output res_valid, best_x, best_y, best_value, best_run,
    input  res_ready
  );

  modport slave (
    input  res_valid, best_x, best_y, best_value, best_run,
    output res_ready
  );
endinterface

// File: rtl/bas_multistart_ctrl.sv
// Multistart sequencer/collector for one bas core.
// Each run resets and loads bas with its own seeds and start point, waits for
// bas_done, and keeps the global minimum (strict compare: ties keep the earlier
// run). The minimum is returned through a valid/ready result port.
// Optional feature: define BAS_MS_WATCHDOG_EN to add a RUN-state watchdog of
// TIMEOUT_CYC cycles; a timed-out run is skipped and timeout_err is set.
module bas_multistart_ctrl #(
  parameter int RUN_W = 8
`ifdef BAS_MS_WATCHDOG_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [RUN_W-1:0]    num_runs,
  input  logic [8:0]          iterations,
  input  logic [8:0]          seed_base_x,
  input  logic [8:0]          seed_base_y,
  input  logic [8:0]          seed_step,
  input  logic [15:0]         x_origin,
  input  logic [15:0]         y_origin,
  input  logic [15:0]         x_step,
  input  logic [15:0]         y_step,
  output logic                busy,
  output logic                bas_reset,
  output logic                bas_load,
  output logic [8:0]          bas_seed_x,
  output logic [8:0]          bas_seed_y,
  output logic [8:0]          bas_iterations,
  output logic [15:0]         bas_x,
  output logic [15:0]         bas_y,
  input  logic [15:0]         bas_x_ext,
  input  logic [15:0]         bas_y_ext,
  input  logic signed [39:0]  bas_value,
  input  logic                bas_done,
  bas_multistart_ctrl_if.master res,
  output logic                timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_LOAD,
    ST_RUN,
    ST_CAPT,
    ST_RESULT
  } state_t;

  localparam logic signed [39:0] VALUE_MAX = 40'sh7F_FFFF_FFFF;

  // Start point of a given run: origin + run*step, wrapping at 16 bits.
  function automatic logic [15:0] point_at(input logic [15:0] origin,
                                           input logic [15:0] step,
                                           input logic [RUN_W-1:0] run);
    return origin + 16'(run) * step;
  endfunction

  // LFSR seed of a given run; an all-zero seed would lock the LFSR up.
  function automatic logic [8:0] seed_at(input logic [8:0] base,
                                         input logic [8:0] step,
                                         input logic [RUN_W-1:0] run);
    logic [8:0] s;
    s = base + 9'(run) * step;
    return (s == 9'h000) ? 9'h001 : s;
  endfunction

  // Control and result state
  state_t             state_q, state_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               busy_q, busy_d;
  logic               bas_load_q, bas_load_d;
  logic               res_valid_q, res_valid_d;
  logic [15:0]        best_x_q, best_x_d;
  logic [15:0]        best_y_q, best_y_d;
  logic signed [39:0] best_value_q, best_value_d;
  logic [RUN_W-1:0]   best_run_q, best_run_d;
  logic [15:0]        bas_x_q, bas_x_d;
  logic [15:0]        bas_y_q, bas_y_d;
  logic [8:0]         bas_seed_x_q, bas_seed_x_d;
  logic [8:0]         bas_seed_y_q, bas_seed_y_d;

  // Configuration captured when a start is accepted
  logic [RUN_W-1:0]   num_runs_q, num_runs_d;
  logic [8:0]         iterations_q, iterations_d;
  logic [8:0]         seed_base_x_q, seed_base_x_d;
  logic [8:0]         seed_base_y_q, seed_base_y_d;
  logic [8:0]         seed_step_q, seed_step_d;
  logic [15:0]        x_origin_q, x_origin_d;
  logic [15:0]        y_origin_q, y_origin_d;
  logic [15:0]        x_step_q, x_step_d;
  logic [15:0]        y_step_q, y_step_d;

  logic               last_run;
  logic [RUN_W-1:0]   run_next;
  logic               wd_expired;

`ifdef BAS_MS_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               timeout_err_q, timeout_err_d;
  assign wd_expired  = (wd_q == WD_W'(TIMEOUT_CYC - 1));
  assign timeout_err = timeout_err_q;
`else
  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign run_next = run_q + RUN_W'(1);
  assign last_run = (run_q == num_runs_q - RUN_W'(1));

  // bas is held in reset whenever the controller is, and for one cycle per run
  assign bas_reset      = reset | (state_q == ST_RST);
  assign bas_load       = bas_load_q;
  assign busy           = busy_q;
  assign bas_x          = bas_x_q;
  assign bas_y          = bas_y_q;
  assign bas_seed_x     = bas_seed_x_q;
  assign bas_seed_y     = bas_seed_y_q;
  assign bas_iterations = iterations_q;

  assign res.res_valid  = res_valid_q;
  assign res.best_x     = best_x_q;
  assign res.best_y     = best_y_q;
  assign res.best_value = best_value_q;
  assign res.best_run   = best_run_q;

  // Next-state, per-run drive and best-so-far tracking
  always_comb begin
    // NOTE: every _d defaults to its _q before the case, so no path can infer a latch.
    state_d       = state_q;
    run_d         = run_q;
    best_x_d      = best_x_q;
    best_y_d      = best_y_q;
    best_value_d  = best_value_q;
    best_run_d    = best_run_q;
    bas_x_d       = bas_x_q;
    bas_y_d       = bas_y_q;
    bas_seed_x_d  = bas_seed_x_q;
    bas_seed_y_d  = bas_seed_y_q;
    num_runs_d    = num_runs_q;
    iterations_d  = iterations_q;
    seed_base_x_d = seed_base_x_q;
    seed_base_y_d = seed_base_y_q;
    seed_step_d   = seed_step_q;
    x_origin_d    = x_origin_q;
    y_origin_d    = y_origin_q;
    x_step_d      = x_step_q;
    y_step_d      = y_step_q;
`ifdef BAS_MS_WATCHDOG_EN
    wd_d          = wd_q;
    timeout_err_d = timeout_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_runs_d    = (num_runs == '0) ? RUN_W'(1) : num_runs;
          iterations_d  = iterations;
          seed_base_x_d = seed_base_x;
          seed_base_y_d = seed_base_y;
          seed_step_d   = seed_step;
          x_origin_d    = x_origin;
          y_origin_d    = y_origin;
          x_step_d      = x_step;
          y_step_d      = y_step;
          run_d         = '0;
          best_value_d  = VALUE_MAX;
          best_x_d      = '0;
          best_y_d      = '0;
          best_run_d    = '0;
          bas_x_d       = x_origin;
          bas_y_d       = y_origin;
          bas_seed_x_d  = seed_at(seed_base_x, seed_step, '0);
          bas_seed_y_d  = seed_at(seed_base_y, seed_step, '0);
`ifdef BAS_MS_WATCHDOG_EN
          timeout_err_d = 1'b0;
`endif
          state_d       = ST_RST;
        end
      end
      ST_RST:  state_d = ST_LOAD;
      ST_LOAD: begin
`ifdef BAS_MS_WATCHDOG_EN
        wd_d = '0;
`endif
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // bas_done is only trusted here; in RST/LOAD it may be a stale level
        if (bas_done) begin
          if (bas_value < best_value_q) begin
            best_value_d = bas_value;
            best_x_d     = bas_x_ext;
            best_y_d     = bas_y_ext;
            best_run_d   = run_q;
          end
          state_d = ST_CAPT;
        end else if (wd_expired) begin
`ifdef BAS_MS_WATCHDOG_EN
          timeout_err_d = 1'b1;
`endif
          state_d = ST_CAPT;
        end else begin
`ifdef BAS_MS_WATCHDOG_EN
          wd_d = wd_q + WD_W'(1);
`endif
        end
      end
      ST_CAPT: begin
        if (last_run) begin
          state_d = ST_RESULT;
        end else begin
          run_d        = run_next;
          bas_x_d      = point_at(x_origin_q, x_step_q, run_next);
          bas_y_d      = point_at(y_origin_q, y_step_q, run_next);
          bas_seed_x_d = seed_at(seed_base_x_q, seed_step_q, run_next);
          bas_seed_y_d = seed_at(seed_base_y_q, seed_step_q, run_next);
          state_d      = ST_RST;
        end
      end
      ST_RESULT: begin
        if (res.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    bas_load_d  = (state_d == ST_LOAD);
    busy_d      = (state_d != ST_IDLE);
    res_valid_d = (state_d == ST_RESULT);
  end

  // Register all controller state; control and results take the synchronous reset
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= ST_IDLE;
      run_q        <= '0;
      busy_q       <= 1'b0;
      bas_load_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      best_x_q     <= '0;
      best_y_q     <= '0;
      best_value_q <= VALUE_MAX;
      best_run_q   <= '0;
      bas_x_q      <= '0;
      bas_y_q      <= '0;
      bas_seed_x_q <= 9'h001;
      bas_seed_y_q <= 9'h001;
`ifdef BAS_MS_WATCHDOG_EN
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      busy_q       <= busy_d;
      bas_load_q   <= bas_load_d;
      res_valid_q  <= res_valid_d;
      best_x_q     <= best_x_d;
      best_y_q     <= best_y_d;
      best_value_q <= best_value_d;
      best_run_q   <= best_run_d;
      bas_x_q      <= bas_x_d;
      bas_y_q      <= bas_y_d;
      bas_seed_x_q <= bas_seed_x_d;
      bas_seed_y_q <= bas_seed_y_d;
`ifdef BAS_MS_WATCHDOG_EN
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
    // NOTE: configuration latches carry no reset; they are always written on start before use.
    num_runs_q    <= num_runs_d;
    iterations_q  <= iterations_d;
    seed_base_x_q <= seed_base_x_d;
    seed_base_y_q <= seed_base_y_d;
    seed_step_q   <= seed_step_d;
    x_origin_q    <= x_origin_d;
    y_origin_q    <= y_origin_d;
    x_step_q      <= x_step_d;
    y_step_q      <= y_step_d;
  end

endmodule

// File: tb/tb_bas_multistart_ctrl.sv
// Directed bench for bas_multistart_ctrl with a behavioural bas stub.
// The stub asserts done a programmable number of cycles after each load (or
// never) and presents per-run values; it logs the drive seen at each load.
module tb_bas_multistart_ctrl;
  localparam int RUN_W = 8;
  localparam logic signed [39:0] VMAX = 40'sh7F_FFFF_FFFF;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [RUN_W-1:0] num_runs = '0;
  logic [8:0]  iterations = '0, seed_base_x = '0, seed_base_y = '0, seed_step = '0;
  logic [15:0] x_origin = '0, y_origin = '0, x_step = '0, y_step = '0;
  logic busy, bas_reset, bas_load, bas_done, timeout_err;
  logic [8:0]  bas_seed_x, bas_seed_y, bas_iterations;
  logic [15:0] bas_x, bas_y, bas_x_ext, bas_y_ext;
  logic signed [39:0] bas_value;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  bas_multistart_ctrl_if #(.RUN_W(RUN_W)) res_if ();

  bas_multistart_ctrl #(
    .RUN_W(RUN_W)
`ifdef BAS_MS_WATCHDOG_EN
    , .TIMEOUT_CYC(64)
`endif
  ) dut (
    .clock(clock), .reset(reset), .start(start), .num_runs(num_runs),
    .iterations(iterations), .seed_base_x(seed_base_x), .seed_base_y(seed_base_y),
    .seed_step(seed_step), .x_origin(x_origin), .y_origin(y_origin),
    .x_step(x_step), .y_step(y_step), .busy(busy), .bas_reset(bas_reset),
    .bas_load(bas_load), .bas_seed_x(bas_seed_x), .bas_seed_y(bas_seed_y),
    .bas_iterations(bas_iterations), .bas_x(bas_x), .bas_y(bas_y),
    .bas_x_ext(bas_x_ext), .bas_y_ext(bas_y_ext), .bas_value(bas_value),
    .bas_done(bas_done), .res(res_if.master), .timeout_err(timeout_err)
  );

  // ---------------- bas stub ----------------
  int                 stub_delay [4];
  logic signed [39:0] stub_val   [4];
  logic [15:0]        stub_xe    [4];
  logic [15:0]        stub_ye    [4];
  logic [15:0]        log_x  [4];
  logic [15:0]        log_y  [4];
  logic [8:0]         log_sx [4];
  logic [8:0]         log_sy [4];
  logic [8:0]         log_it [4];
  int       load_cnt = 0;
  int       cnt      = 0;
  bit       active   = 1'b0;
  logic     done_r   = 1'b0;
  logic [1:0] cur    = 2'd0;
  logic     stub_clr = 1'b0;

  assign bas_done  = done_r;
  assign bas_value = stub_val[cur];
  assign bas_x_ext = stub_xe[cur];
  assign bas_y_ext = stub_ye[cur];

  always @(posedge clock) begin
    if (stub_clr) load_cnt <= 0;
    if (bas_reset) begin
      done_r <= 1'b0;
      active <= 1'b0;
    end else if (bas_load) begin
      active <= 1'b1;
      cnt    <= 0;
      cur    <= load_cnt[1:0];
      log_x[load_cnt[1:0]]  <= bas_x;
      log_y[load_cnt[1:0]]  <= bas_y;
      log_sx[load_cnt[1:0]] <= bas_seed_x;
      log_sy[load_cnt[1:0]] <= bas_seed_y;
      log_it[load_cnt[1:0]] <= bas_iterations;
      load_cnt <= load_cnt + 1;
    end else if (active && !done_r) begin
      if (stub_delay[cur] >= 0 && cnt >= stub_delay[cur] - 1) done_r <= 1'b1;
      cnt <= cnt + 1;
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_run(input int i, input int d, input logic signed [39:0] v,
                         input logic [15:0] xe, input logic [15:0] ye);
    stub_delay[i] = d;
    stub_val[i]   = v;
    stub_xe[i]    = xe;
    stub_ye[i]    = ye;
  endtask

  // Clears stub log, pulses start; returns at the negedge of cycle T+1.
  task automatic kick();
    stub_clr = 1'b1;
    tick();
    stub_clr = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (res_if.res_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic handshake();
    res_if.res_ready = 1'b1;
    tick();
    res_if.res_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick(3);
    n_checks++; if (bas_reset !== 1'b1) $display("FAIL reset_bas_reset got=%0h want=1", bas_reset); else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0h want=0", busy); else n_pass++;
    n_checks++; if (res_if.res_valid !== 1'b0) $display("FAIL reset_res_valid got=%0h want=0", res_if.res_valid); else n_pass++;
    n_checks++; if (bas_load !== 1'b0) $display("FAIL reset_bas_load got=%0h want=0", bas_load); else n_pass++;
    n_checks++; if (bas_reset !== 1'b0) $display("FAIL reset_bas_reset_rel got=%0h want=0", bas_reset); else n_pass++;
    n_checks++; if (res_if.best_value !== VMAX) $display("FAIL reset_best_value got=%0h want=%0h", res_if.best_value, VMAX); else n_pass++;
    n_checks++; if (res_if.best_x !== 16'h0 || res_if.best_y !== 16'h0 || res_if.best_run !== 8'h0)
      $display("FAIL reset_best_xyr got=%0h/%0h/%0h want=0/0/0", res_if.best_x, res_if.best_y, res_if.best_run); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err got=%0h want=0", timeout_err); else n_pass++;
  endtask

  task automatic test_single_run();
    bit ok;
    num_runs = 8'd1; iterations = 9'd100;
    seed_base_x = 9'h055; seed_base_y = 9'h0AA; seed_step = 9'd3;
    x_origin = 16'h0100; y_origin = 16'h0200; x_step = 16'h0080; y_step = 16'h0080;
    set_run(0, 20, 40'sh300, 16'h0110, 16'h0220);
    kick();
    x_origin = 16'hDEAD;  // changes after accept must not matter
    n_checks++; if (bas_reset !== 1'b1) $display("FAIL t1_bas_reset_T1 got=%0h want=1", bas_reset); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL t1_busy_T1 got=%0h want=1", busy); else n_pass++;
    n_checks++; if (bas_load !== 1'b0) $display("FAIL t1_bas_load_T1 got=%0h want=0", bas_load); else n_pass++;
    tick();
    n_checks++; if (bas_load !== 1'b1) $display("FAIL t1_bas_load_T2 got=%0h want=1", bas_load); else n_pass++;
    n_checks++; if (bas_reset !== 1'b0) $display("FAIL t1_bas_reset_T2 got=%0h want=0", bas_reset); else n_pass++;
    n_checks++; if (bas_x !== 16'h0100 || bas_y !== 16'h0200) $display("FAIL t1_bas_xy got=%0h/%0h want=100/200", bas_x, bas_y); else n_pass++;
    n_checks++; if (bas_seed_x !== 9'h055 || bas_seed_y !== 9'h0AA) $display("FAIL t1_seeds got=%0h/%0h want=55/aa", bas_seed_x, bas_seed_y); else n_pass++;
    n_checks++; if (bas_iterations !== 9'd100) $display("FAIL t1_iterations got=%0d want=100", bas_iterations); else n_pass++;
    wait_valid(200, ok);
    n_checks++; if (!ok) $display("FAIL t1_valid_timeout got=no_valid want=valid"); else n_pass++;
    n_checks++; if (res_if.best_x !== 16'h0110 || res_if.best_y !== 16'h0220)
      $display("FAIL t1_best_xy got=%0h/%0h want=110/220", res_if.best_x, res_if.best_y); else n_pass++;
    n_checks++; if (res_if.best_value !== 40'sh300) $display("FAIL t1_best_value got=%0h want=300", res_if.best_value); else n_pass++;
    n_checks++; if (res_if.best_run !== 8'd0) $display("FAIL t1_best_run got=%0d want=0", res_if.best_run); else n_pass++;
    handshake();
    n_checks++; if (res_if.res_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL t1_after_hs got=valid%0h/busy%0h want=0/0", res_if.res_valid, busy); else n_pass++;
  endtask

  task automatic test_three_runs();
    bit ok;
    num_runs = 8'd3; iterations = 9'd50;
    seed_base_x = 9'h010; seed_base_y = 9'h020; seed_step = 9'd5;
    x_origin = 16'h0100; x_step = 16'h0080; y_origin = 16'h0040; y_step = 16'hFF80;
    set_run(0, 4, 40'sh500, 16'h0001, 16'h0002);
    set_run(1, 6, 40'sh200, 16'h0011, 16'h0012);
    set_run(2, 5, 40'sh200, 16'h0021, 16'h0022);
    kick();
    wait_valid(400, ok);
    n_checks++; if (!ok) $display("FAIL t2_valid_timeout got=no_valid want=valid"); else n_pass++;
    n_checks++; if (load_cnt !== 3) $display("FAIL t2_load_count got=%0d want=3", load_cnt); else n_pass++;
    n_checks++; if (res_if.best_value !== 40'sh200) $display("FAIL t2_best_value got=%0h want=200", res_if.best_value); else n_pass++;
    n_checks++; if (res_if.best_run !== 8'd1) $display("FAIL t2_best_run got=%0d want=1", res_if.best_run); else n_pass++;
    n_checks++; if (res_if.best_x !== 16'h0011 || res_if.best_y !== 16'h0012)
      $display("FAIL t2_best_xy got=%0h/%0h want=11/12", res_if.best_x, res_if.best_y); else n_pass++;
    n_checks++; if (log_x[0] !== 16'h0100 || log_x[1] !== 16'h0180 || log_x[2] !== 16'h0200)
      $display("FAIL t2_bas_x got=%0h/%0h/%0h want=100/180/200", log_x[0], log_x[1], log_x[2]); else n_pass++;
    n_checks++; if (log_y[0] !== 16'h0040 || log_y[1] !== 16'hFFC0 || log_y[2] !== 16'hFF40)
      $display("FAIL t2_bas_y got=%0h/%0h/%0h want=40/ffc0/ff40", log_y[0], log_y[1], log_y[2]); else n_pass++;
    n_checks++; if (log_sx[1] !== 9'h015 || log_sy[2] !== 9'h02A)
      $display("FAIL t2_seeds got=%0h/%0h want=15/2a", log_sx[1], log_sy[2]); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL t2_timeout_err got=%0h want=0", timeout_err); else n_pass++;
    handshake();
  endtask

  task automatic test_seed_wrap();
    bit ok;
    num_runs = 8'd2; seed_base_x = 9'h1FF; seed_base_y = 9'h000; seed_step = 9'd1;
    set_run(0, 3, 40'sh40, 16'h1, 16'h1);
    set_run(1, 3, 40'sh41, 16'h2, 16'h2);
    kick();
    wait_valid(200, ok);
    n_checks++; if (!ok) $display("FAIL t3_valid_timeout got=no_valid want=valid"); else n_pass++;
    n_checks++; if (log_sx[0] !== 9'h1FF || log_sx[1] !== 9'h001)
      $display("FAIL t3_seed_x got=%0h/%0h want=1ff/1", log_sx[0], log_sx[1]); else n_pass++;
    n_checks++; if (log_sy[0] !== 9'h001 || log_sy[1] !== 9'h001)
      $display("FAIL t3_seed_y got=%0h/%0h want=1/1", log_sy[0], log_sy[1]); else n_pass++;
    handshake();
  endtask

  task automatic test_result_hold();
    bit ok;
    num_runs = 8'd1;
    set_run(0, 4, 40'sh42, 16'h0033, 16'h0044);
    kick();
    wait_valid(200, ok);
    n_checks++; if (!ok) $display("FAIL t4_valid_timeout got=no_valid want=valid"); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      start = (i >= 2 && i < 6);
      n_checks++; if (res_if.res_valid !== 1'b1) $display("FAIL t4_hold_valid cyc=%0d got=%0h want=1", i, res_if.res_valid); else n_pass++;
      n_checks++; if (res_if.best_value !== 40'sh42 || res_if.best_x !== 16'h0033 || res_if.best_y !== 16'h0044)
        $display("FAIL t4_hold_data cyc=%0d got=%0h/%0h/%0h want=42/33/44", i, res_if.best_value, res_if.best_x, res_if.best_y); else n_pass++;
      tick();
    end
    start = 1'b0;
    n_checks++; if (load_cnt !== 1) $display("FAIL t4_start_ignored got=%0d loads want=1", load_cnt); else n_pass++;
    handshake();
    n_checks++; if (res_if.res_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL t4_after_hs got=valid%0h/busy%0h want=0/0", res_if.res_valid, busy); else n_pass++;
    tick(5);
    n_checks++; if (busy !== 1'b0 || load_cnt !== 1) $display("FAIL t4_idle got=busy%0h/loads%0d want=0/1", busy, load_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int guard;
    num_runs = 8'd3; x_origin = 16'h0100; x_step = 16'h0080;
    set_run(0, 3, 40'sh100, 16'h5, 16'h6);
    set_run(1, -1, 40'sh0, 16'h0, 16'h0);
    set_run(2, 3, 40'sh0, 16'h0, 16'h0);
    kick();
    guard = 0;
    while (load_cnt < 2 && guard < 200) begin
      tick();
      guard++;
    end
    n_checks++; if (load_cnt !== 2) $display("FAIL t5_second_load got=%0d loads want=2", load_cnt); else n_pass++;
    tick(5);
    n_checks++; if (busy !== 1'b1) $display("FAIL t5_busy_in_run got=%0h want=1", busy); else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0 || res_if.res_valid !== 1'b0)
      $display("FAIL t5_reset_idle got=busy%0h/valid%0h want=0/0", busy, res_if.res_valid); else n_pass++;
    n_checks++; if (res_if.best_value !== VMAX) $display("FAIL t5_best_cleared got=%0h want=%0h", res_if.best_value, VMAX); else n_pass++;
    n_checks++; if (bas_reset !== 1'b1) $display("FAIL t5_bas_reset got=%0h want=1", bas_reset); else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL t5_stay_idle got=%0h want=0", busy); else n_pass++;
    num_runs = 8'd1; x_origin = 16'h0700;
    set_run(0, 3, 40'sh77, 16'h7, 16'h8);
    kick();
    wait_valid(200, ok);
    n_checks++; if (!ok) $display("FAIL t5_valid_timeout got=no_valid want=valid"); else n_pass++;
    n_checks++; if (log_x[0] !== 16'h0700 || res_if.best_run !== 8'd0 || res_if.best_value !== 40'sh77)
      $display("FAIL t5_restart got=x%0h/run%0d/val%0h want=700/0/77", log_x[0], res_if.best_run, res_if.best_value); else n_pass++;
    handshake();
  endtask

  task automatic test_back_to_back();
    bit ok;
    num_runs = 8'd0;
    set_run(0, 3, -40'sd5, 16'h00A1, 16'h00A2);
    kick();
    wait_valid(200, ok);
    n_checks++; if (!ok) $display("FAIL t6_valid_timeout got=no_valid want=valid"); else n_pass++;
    n_checks++; if (load_cnt !== 1) $display("FAIL t6_zero_runs got=%0d loads want=1", load_cnt); else n_pass++;
    n_checks++; if (res_if.best_value !== -40'sd5 || res_if.best_run !== 8'd0)
      $display("FAIL t6_negative got=%0h/run%0d want=fffffffffb/0", res_if.best_value, res_if.best_run); else n_pass++;
    handshake();
    // restart straight after the handshake
    num_runs = 8'd2;
    set_run(0, 3, 40'sh10, 16'h00B1, 16'h00B2);
    set_run(1, 3, -40'sd32, 16'h00C1, 16'h00C2);
    stub_clr = 1'b1;
    start = 1'b1;
    tick();
    stub_clr = 1'b0;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL t6_restart_busy got=%0h want=1", busy); else n_pass++;
    wait_valid(300, ok);
    n_checks++; if (!ok) $display("FAIL t6_valid2_timeout got=no_valid want=valid"); else n_pass++;
    n_checks++; if (load_cnt !== 2 || res_if.best_value !== -40'sd32 || res_if.best_run !== 8'd1 || res_if.best_x !== 16'h00C1)
      $display("FAIL t6_second got=loads%0d/%0h/run%0d/x%0h want=2/ffffffffe0/1/c1",
               load_cnt, res_if.best_value, res_if.best_run, res_if.best_x); else n_pass++;
    handshake();
  endtask

`ifdef BAS_MS_WATCHDOG_EN
  task automatic test_watchdog();
    bit ok;
    num_runs = 8'd2;
    set_run(0, -1, 40'sh1, 16'h1, 16'h1);
    set_run(1, 5, 40'sh10, 16'h00D1, 16'h00D2);
    kick();
    wait_valid(500, ok);
    n_checks++; if (!ok) $display("FAIL t7_valid_timeout got=no_valid want=valid"); else n_pass++;
    n_checks++; if (timeout_err !== 1'b1) $display("FAIL t7_timeout_err got=%0h want=1", timeout_err); else n_pass++;
    n_checks++; if (res_if.best_run !== 8'd1 || res_if.best_value !== 40'sh10 || load_cnt !== 2)
      $display("FAIL t7_best got=run%0d/%0h/loads%0d want=1/10/2", res_if.best_run, res_if.best_value, load_cnt); else n_pass++;
    handshake();
  endtask
`endif

  initial begin
    res_if.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) set_run(i, 3, 40'sh0, 16'h0, 16'h0);
    test_reset();
    test_single_run();
    test_three_runs();
    test_seed_wrap();
    test_result_hold();
    test_reset_mid_run();
    test_back_to_back();
`ifdef BAS_MS_WATCHDOG_EN
    test_watchdog();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=still_running want=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
